// File: rtl/fpu_issue_queue.sv
// fpu_issue_queue: in-order request FIFO in front of the FP unit. It assigns a
// wrapping tag to each request and limits how many operations are in flight.
// Latency: 1 cycle minimum from push to offer. There is no fall-through path.
// Backpressure: req_ready drops when the queue is full. The FPU is offered an
// entry only while outstanding < MAX_OUT.
// Ports:
//   clk_i, rst_i (sync, active-high), flush_i
//   req_*    upstream valid/ready request {operands, op, op_mod, rnd}
//   fpu_*    downstream valid/ready issue {operands, op, op_mod, rnd, tag}
//   fpu_done_i: one completion per pulse
//   count_o, outstanding_o, err_o (sticky completion underflow)
module fpu_issue_queue #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [3*WIDTH-1:0]           req_operands_i,
  input  logic [3:0]                   req_op_i,
  input  logic                         req_op_mod_i,
  input  logic [2:0]                   req_rnd_i,
  output logic                         fpu_in_valid_o,
  input  logic                         fpu_in_ready_i,
  output logic [3*WIDTH-1:0]           fpu_operands_o,
  output logic [3:0]                   fpu_op_o,
  output logic                         fpu_op_mod_o,
  output logic [2:0]                   fpu_rnd_o,
  output logic [TAG_W-1:0]             fpu_tag_o,
  input  logic                         fpu_done_i,
  output logic [$clog2(DEPTH):0]       count_o,
  output logic [$clog2(MAX_OUT):0]     outstanding_o,
  output logic                         err_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OUT_W = $clog2(MAX_OUT) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [OUT_W-1:0] MAX_C   = OUT_W'(MAX_OUT);

  typedef struct packed {
    logic [3*WIDTH-1:0] operands;
    logic [3:0]         op;
    logic               op_mod;
    logic [2:0]         rnd;
    logic [TAG_W-1:0]   tag;
  } entry_t;

  entry_t            mem [DEPTH];
  entry_t            head;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [OUT_W-1:0]  outstanding;
  logic [TAG_W-1:0]  tag_cnt;
  logic              err;
  logic              push;
  logic              pop;

  // Ready uses the registered count, so a full queue refuses a push even
  // when a pop happens in the same cycle.
  assign req_ready_o    = (count < DEPTH_C) && !flush_i;
  assign fpu_in_valid_o = (count != '0) && (outstanding < MAX_C);
  assign push           = req_valid_i && req_ready_o;
  assign pop            = fpu_in_valid_o && fpu_in_ready_i;

  // The payload comes straight from storage. It stays stable while stalled
  // because rd_ptr moves only on a pop.
  assign head           = mem[rd_ptr];
  assign fpu_operands_o = head.operands;
  assign fpu_op_o       = head.op;
  assign fpu_op_mod_o   = head.op_mod;
  assign fpu_rnd_o      = head.rnd;
  assign fpu_tag_o      = head.tag;
  assign count_o        = count;
  assign outstanding_o  = outstanding;
  assign err_o          = err;

  // Storage needs no reset. Entries are only observed while count != 0.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      mem[wr_ptr] <= '{operands: req_operands_i, op: req_op_i,
                       op_mod: req_op_mod_i, rnd: req_rnd_i, tag: tag_cnt};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      tag_cnt     <= '0;
      err         <= 1'b0;
    end else if (flush_i) begin
      // Flush behaves like reset, except that err stays sticky.
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      tag_cnt     <= '0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + 1'b1;
        tag_cnt <= tag_cnt + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase

      // A completion with nothing in flight is an underflow. The counter
      // holds at zero and the error is latched.
      case ({pop, fpu_done_i})
        2'b10: outstanding <= outstanding + 1'b1;
        2'b01: begin
          if (outstanding == '0) begin
            err <= 1'b1;
          end else begin
            outstanding <= outstanding - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_issue_queue.sv
module tb_fpu_issue_queue;
  localparam int W  = 16;
  localparam int D  = 4;
  localparam int TW = 4;
  localparam int MO = 2;

  logic          clk = 1'b0;
  logic          rst, flush, req_valid, req_ready, req_op_mod;
  logic [3*W-1:0] req_operands, fpu_operands;
  logic [3:0]    req_op, fpu_op;
  logic [2:0]    req_rnd, fpu_rnd;
  logic          fpu_in_valid, fpu_in_ready, fpu_op_mod, fpu_done, err;
  logic [TW-1:0] fpu_tag;
  logic [2:0]    count;
  logic [1:0]    outstanding;

  always #5 clk = ~clk;

  fpu_issue_queue #(.WIDTH(W), .DEPTH(D), .TAG_W(TW), .MAX_OUT(MO)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_operands_i(req_operands), .req_op_i(req_op),
    .req_op_mod_i(req_op_mod), .req_rnd_i(req_rnd),
    .fpu_in_valid_o(fpu_in_valid), .fpu_in_ready_i(fpu_in_ready),
    .fpu_operands_o(fpu_operands), .fpu_op_o(fpu_op),
    .fpu_op_mod_o(fpu_op_mod), .fpu_rnd_o(fpu_rnd), .fpu_tag_o(fpu_tag),
    .fpu_done_i(fpu_done), .count_o(count), .outstanding_o(outstanding),
    .err_o(err)
  );

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rv, input logic [47:0] ops, input logic [3:0] op,
                       input logic fr, input logic dn, input logic fl, input logic rs);
    req_valid    = rv;
    req_operands = ops;
    req_op       = op;
    req_op_mod   = op[0];
    req_rnd      = op[2:0];
    fpu_in_ready = fr;
    fpu_done     = dn;
    flush        = fl;
    rst          = rs;
  endtask

  task automatic idle();
    drive(1'b0, 48'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 48'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    idle();
    #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        rv;
    logic [47:0] ops;
    logic [3:0]  op;
    logic        fr, dn, fl, rs;
    logic        e_vld, e_rdy;
    int          e_cnt, e_out;
    logic        e_err;
    int          e_tag;    // -1: payload not checked
    logic [47:0] e_ops;
  } vec_t;

  function automatic vec_t mk(logic rv, logic [47:0] ops, logic fr, logic dn, logic fl,
                              logic rs, logic e_vld, logic e_rdy, int e_cnt, int e_out,
                              logic e_err, int e_tag, logic [47:0] e_ops);
    vec_t v;
    v.rv = rv; v.ops = ops; v.op = 4'h2; v.fr = fr; v.dn = dn; v.fl = fl; v.rs = rs;
    v.e_vld = e_vld; v.e_rdy = e_rdy; v.e_cnt = e_cnt; v.e_out = e_out;
    v.e_err = e_err; v.e_tag = e_tag; v.e_ops = e_ops;
    return v;
  endfunction

  localparam logic [47:0] A  = 48'h0000_4000_3C00;
  localparam logic [47:0] X1 = 48'h1111_2222_3333;
  localparam logic [47:0] X2 = 48'h4444_5555_6666;
  localparam logic [47:0] X3 = 48'h7777_8888_9999;
  localparam logic [47:0] X4 = 48'hAAAA_BBBB_CCCC;
  localparam logic [47:0] X5 = 48'hDDDD_EEEE_FFFF;
  localparam logic [47:0] X6 = 48'h0123_4567_89AB;
  localparam logic [47:0] Y  = 48'hFEDC_BA98_7654;

  vec_t tbl[16];

  // ---------------- reference model ----------------
  typedef struct {
    logic [47:0] ops;
    logic [3:0]  op;
    logic        mod;
    logic [2:0]  rnd;
    int          tag;
  } ent_t;

  ent_t m_q[$];
  int   m_tag, m_out;
  logic m_err;

  task automatic model_step(input logic rv, input logic [47:0] ops, input logic [3:0] op,
                            input logic fr, input logic dn, input logic fl, input logic rs);
    ent_t e;
    bit   do_pop, do_push;
    if (rs) begin
      m_q.delete(); m_tag = 0; m_out = 0; m_err = 1'b0;
    end else if (fl) begin
      m_q.delete(); m_tag = 0; m_out = 0;
    end else begin
      do_pop  = (m_q.size() > 0) && (m_out < MO) && fr;
      do_push = rv && (m_q.size() < D);
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        e.ops = ops; e.op = op; e.mod = op[0]; e.rnd = op[2:0]; e.tag = m_tag;
        m_q.push_back(e);
        m_tag = (m_tag + 1) % (1 << TW);
      end
      if (do_pop && !dn) m_out++;
      else if (dn && !do_pop) begin
        if (m_out == 0) m_err = 1'b1;
        else m_out--;
      end
    end
  endtask

  task automatic model_check(input logic fl);
    logic exp_vld;
    exp_vld = (m_q.size() != 0) && (m_out < MO);
    chk("rnd_rdy", req_ready, (m_q.size() < D) && !fl);
    chk("rnd_vld", fpu_in_valid, exp_vld);
    chk("rnd_cnt", count, m_q.size());
    chk("rnd_out", outstanding, m_out);
    chk("rnd_err", err, m_err);
    if (exp_vld) begin
      chk("rnd_ops", fpu_operands, m_q[0].ops);
      chk("rnd_op",  {fpu_op, fpu_op_mod, fpu_rnd}, {m_q[0].op, m_q[0].mod, m_q[0].rnd});
      chk("rnd_tag", fpu_tag, m_q[0].tag);
    end
  endtask

  initial begin
    logic [47:0] r_ops;
    logic [3:0]  r_op;
    logic        r_rv, r_fr, r_dn, r_fl, r_rs;
    int          acc;

    // row: rv ops fr dn fl rs | vld rdy cnt out err tag ops
    tbl[0]  = mk(1, A,  1, 0, 0, 0,  1, 1, 1, 0, 0,  0, A);   // push ADD
    tbl[1]  = mk(0, 0,  1, 0, 0, 0,  0, 1, 0, 1, 0, -1, 0);   // issue
    tbl[2]  = mk(1, X1, 0, 0, 0, 0,  1, 1, 1, 1, 0,  1, X1);
    tbl[3]  = mk(1, X2, 0, 0, 0, 0,  1, 1, 2, 1, 0,  1, X1);
    tbl[4]  = mk(1, X3, 1, 0, 0, 0,  0, 1, 2, 2, 0, -1, 0);   // push+pop at 2, hits cap
    tbl[5]  = mk(0, 0,  1, 0, 0, 0,  0, 1, 2, 2, 0, -1, 0);   // capped, no issue
    tbl[6]  = mk(0, 0,  1, 1, 0, 0,  1, 1, 2, 1, 0,  2, X2);  // done frees a slot
    tbl[7]  = mk(0, 0,  1, 1, 0, 0,  1, 1, 1, 1, 0,  3, X3);  // issue+done at out=1
    tbl[8]  = mk(1, X4, 1, 0, 0, 0,  0, 1, 1, 2, 0, -1, 0);
    tbl[9]  = mk(1, X5, 0, 0, 0, 0,  0, 1, 2, 2, 0, -1, 0);
    tbl[10] = mk(1, X6, 0, 0, 0, 0,  0, 1, 3, 2, 0, -1, 0);   // cnt=3 out=2
    tbl[11] = mk(1, X1, 1, 1, 1, 0,  0, 1, 0, 0, 0, -1, 0);   // flush wins
    tbl[12] = mk(0, 0,  0, 1, 0, 0,  0, 1, 0, 0, 1, -1, 0);   // underflow
    tbl[13] = mk(0, 0,  0, 0, 0, 0,  0, 1, 0, 0, 1, -1, 0);   // sticky
    tbl[14] = mk(1, Y,  0, 0, 0, 0,  1, 1, 1, 0, 1,  0, Y);   // tag restarted
    tbl[15] = mk(0, 0,  0, 0, 0, 1,  0, 1, 0, 0, 0, -1, 0);   // reset clears err

    idle();
    do_reset();
    chk("rst_vld", fpu_in_valid, 1'b0);
    chk("rst_rdy", req_ready, 1'b1);
    chk("rst_cnt", count, 0);
    chk("rst_out", outstanding, 0);
    chk("rst_err", err, 1'b0);

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].rv, tbl[i].ops, tbl[i].op, tbl[i].fr, tbl[i].dn, tbl[i].fl, tbl[i].rs);
      if (i == 0) chk("no_fallthru", fpu_in_valid, 1'b0);
      tick();
      idle();
      #1;
      chk($sformatf("t%0d_vld", i), fpu_in_valid, tbl[i].e_vld);
      chk($sformatf("t%0d_rdy", i), req_ready, tbl[i].e_rdy);
      chk($sformatf("t%0d_cnt", i), count, tbl[i].e_cnt);
      chk($sformatf("t%0d_out", i), outstanding, tbl[i].e_out);
      chk($sformatf("t%0d_err", i), err, tbl[i].e_err);
      if (tbl[i].e_tag >= 0) begin
        chk($sformatf("t%0d_tag", i), fpu_tag, tbl[i].e_tag);
        chk($sformatf("t%0d_ops", i), fpu_operands, tbl[i].e_ops);
      end
    end

    // Stall: five pushes, four accepted, head stays put.
    do_reset();
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 48'h1000 + 48'(i), 4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      if (req_ready) acc++;
      tick();
      idle();
      #1;
      chk("stall_head", fpu_operands, 48'h1000);
      chk("stall_tag", fpu_tag, 0);
    end
    chk("stall_acc", acc, 4);
    chk("stall_cnt", count, 4);
    chk("stall_rdy", req_ready, 1'b0);

    // Tag wrap over 18 requests.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      drive(1'b1, 48'(i), 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b0, 48'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      chk("wrap_vld", fpu_in_valid, 1'b1);
      chk($sformatf("wrap_tag%0d", i), fpu_tag, i % 16);
      tick();
      drive(1'b0, 48'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      idle();
    end
    chk("wrap_out", outstanding, 0);
    chk("wrap_err", err, 1'b0);

    // Randomised run against the queue model.
    do_reset();
    model_step(1'b0, 48'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 3000; c++) begin
      r_ops = {$urandom, $urandom};
      r_op  = 4'($urandom);
      r_rv  = ($urandom_range(0, 9) < 7);
      r_fr  = ($urandom_range(0, 9) < 6);
      r_dn  = (m_out > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 49) == 0);
      r_fl  = ($urandom_range(0, 59) == 0);
      r_rs  = ($urandom_range(0, 199) == 0);
      drive(r_rv, r_ops, r_op, r_fr, r_dn, r_fl, r_rs);
      #1;
      model_check(r_fl);
      model_step(r_rv, r_ops, r_op, r_fr, r_dn, r_fl, r_rs);
      tick();
    end
    idle();
    #1;
    model_check(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
